inst_queue: RTL
===============

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of queue entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port flush  input  1  synchronous clear of all queued entries.
REQ-005 SHALL have port in_valid  input  1  fetch presents an instruction.
REQ-006 SHALL have port in_instr  input  32  RV32 instruction word from fetch.
REQ-007 SHALL have port in_ready  output  1  queue can accept this cycle.
REQ-008 SHALL have port struct_haz  input  1  order manager cannot accept the head this cycle.
REQ-009 SHALL have port start  output  1  head entry valid and presented to the order manager.
REQ-010 SHALL have port instruction  output  32  head instruction word.
REQ-011 SHALL have port operation  output  3  head decoded operation code.
REQ-012 SHALL have ports rs1, rs2, rd  output  5 each  head register fields.
REQ-013 SHALL have port count  output  5  number of valid entries, 0..DEPTH.
REQ-014 SHALL have port illegal  output  1  one-cycle pulse: an accepted word was undecodable and discarded.

Function
REQ-015 SHALL decode at write: opcode 0110011/f3 000/f7 0000000 -> 0 ADD; f7 0100000 -> 1 SUB; f7 0000001 -> 2 MUL; opcode 0010011/f3 000 -> 3 ADDI; opcode 0000011/f3 010 -> 4 LW; opcode 0100011/f3 010 -> 5 SW; any other word -> illegal.
REQ-016 SHALL store per entry {instruction, operation}; rs1 = [19:15], rs2 = [24:20], rd = [11:7] taken from the stored word.
REQ-017 SHALL drive rd = 0 for operation 5 (SW) and rs2 = 0 for operations 3 and 4.
REQ-018 SHALL drive in_ready = !full && !flush.
REQ-019 SHALL accept a word when in_valid && in_ready; a legal word is written at the tail and the tail advances; an illegal word is not written, and illegal is 1 in the next cycle.
REQ-020 SHALL drive start = (count != 0); head outputs come from registered storage only, with no combinational path from in_* to start or to the head fields.
REQ-021 SHALL dequeue the head when start && !struct_haz; the head outputs SHALL hold stable while start && struct_haz.
REQ-022 SHALL have one-cycle latency: a word accepted in cycle N appears at the head no earlier than cycle N+1 (no bypass when empty).
REQ-023 SHALL wrap head and tail pointers modulo DEPTH.
REQ-024 SHALL allow push and pop in the same cycle when not full and not empty, leaving count unchanged.
REQ-025 SHALL refuse pushes when full, even with a simultaneous pop; a pop when full SHALL decrement count normally.
REQ-026 SHALL give flush priority over push and pop: next cycle count = 0, pointers = 0, start = 0, illegal = 0.
REQ-027 SHALL drive outputs to 0 when count = 0, except in_ready.

Reset
REQ-028 SHALL on rst set head = tail = 0, count = 0, start = 0, illegal = 0, all head fields = 0, in_ready = 1 from the following cycle.
REQ-029 SHALL give rst priority over flush, push and pop; entries in flight at reset are discarded.
REQ-030 SHALL NOT require storage array contents to be reset.

Structure
REQ-031 SHALL take the operation encodings (0..5) and opcode/funct constants from a shared package, which order_manager and the reservation stations also use.
REQ-032 SHALL contain one sub-module, inst_decode, a combinational decoder mapping a 32-bit word to {operation, legal}.

Verification
REQ-033 SHALL cover: push 0x002081B3 (add x3,x1,x2) into an empty queue -> cycle+1 start=1, operation=0, rs1=1, rs2=2, rd=3, count=1.
REQ-034 SHALL cover: 8 pushes with struct_haz=1 -> count=8, in_ready=0, a 9th word is not accepted, and the head stays equal to the first word.
REQ-035 SHALL cover: full queue with struct_haz=0 and in_valid=1 -> one pop, no push, count=7; the next cycle accepts a push with count=7.
REQ-036 SHALL cover: push 0xFFFFFFFF -> illegal pulses for 1 cycle, count is unchanged, start is unchanged.
REQ-037 SHALL cover: 20 streaming push/pop cycles with random struct_haz -> issue order equals push order across pointer wrap, with no loss or duplication.
REQ-038 SHALL cover: count=5, then flush=1 together with in_valid=1 -> next cycle count=0 and start=0; a rst pulse mid-stream also gives count=0.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Shared operation encodings and RV32 opcode/funct constants used by the
// instruction queue, order manager and reservation stations.
package inst_queue_pkg;

    typedef enum logic [2:0] {
        OpAdd  = 3'd0,
        OpSub  = 3'd1,
        OpMul  = 3'd2,
        OpAddi = 3'd3,
        OpLw   = 3'd4,
        OpSw   = 3'd5
    } op_e;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;

    localparam logic [2:0] F3AddSub  = 3'b000;
    localparam logic [2:0] F3Word    = 3'b010;

    localparam logic [6:0] F7Base    = 7'b0000000;
    localparam logic [6:0] F7Sub     = 7'b0100000;
    localparam logic [6:0] F7MulDiv  = 7'b0000001;

    // Stores carry no destination; immediate forms carry no second source.
    function automatic logic op_has_rd(logic [2:0] op);
        return op != OpSw;
    endfunction

    function automatic logic op_has_rs2(logic [2:0] op);
        return (op == OpAdd) || (op == OpSub) || (op == OpMul) || (op == OpSw);
    endfunction

endpackage

// File: rtl/inst_queue_decode.sv
// Combinational decoder: maps an RV32 word onto the queue's operation code
// and flags words outside the supported subset.
module inst_decode
    import inst_queue_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [2:0]  operation_o,
    output logic        legal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        operation_o = OpAdd;
        legal_o     = 1'b0;
        case (opcode)
            OpcOp: begin
                if (funct3 == F3AddSub) begin
                    case (funct7)
                        F7Base:   begin operation_o = OpAdd; legal_o = 1'b1; end
                        F7Sub:    begin operation_o = OpSub; legal_o = 1'b1; end
                        F7MulDiv: begin operation_o = OpMul; legal_o = 1'b1; end
                        default:  ;
                    endcase
                end
            end
            OpcOpImm: begin
                if (funct3 == F3AddSub) begin
                    operation_o = OpAddi;
                    legal_o     = 1'b1;
                end
            end
            OpcLoad: begin
                if (funct3 == F3Word) begin
                    operation_o = OpLw;
                    legal_o     = 1'b1;
                end
            end
            OpcStore: begin
                if (funct3 == F3Word) begin
                    operation_o = OpSw;
                    legal_o     = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/inst_queue.sv
// Decoded instruction FIFO between fetch and the order manager. Words are
// decoded on entry; the head is presented from registered storage only.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    input  logic        struct_haz,
    output logic        start,
    output logic [31:0] instruction,
    output logic [2:0]  operation,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [4:0]  count,
    output logic        illegal
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [4:0]      count_q, count_d;
    logic            illegal_q, illegal_d;

    logic [31:0] instr_mem [DEPTH];
    logic [2:0]  op_mem    [DEPTH];

    logic [2:0]  dec_op;
    logic        dec_legal;
    logic        full, accept, push, pop;
    logic [31:0] head_instr;
    logic [2:0]  head_op;

    inst_decode u_decode (
        .instr_i     (in_instr),
        .operation_o (dec_op),
        .legal_o     (dec_legal)
    );

    assign full     = count_q == 5'(DEPTH);
    assign in_ready = !full && !flush;
    assign start    = count_q != 5'd0;
    assign accept   = in_valid && in_ready;
    assign push     = accept && dec_legal;
    assign pop      = start && !struct_haz;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        illegal_d = accept && !dec_legal;
        if (flush) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = 5'd0;
            illegal_d = 1'b0;
        end else begin
            // Power-of-two depth lets the pointers wrap by plain overflow.
            if (push) tail_d = tail_q + PtrW'(1);
            if (pop)  head_d = head_q + PtrW'(1);
            count_d = count_q + {4'b0, push} - {4'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= 5'd0;
            illegal_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    // Storage is not reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            instr_mem[tail_q] <= in_instr;
            op_mem[tail_q]    <= dec_op;
        end
    end

    assign head_instr = instr_mem[head_q];
    assign head_op    = op_mem[head_q];

    always_comb begin
        instruction = 32'h0;
        operation   = 3'd0;
        rs1         = 5'd0;
        rs2         = 5'd0;
        rd          = 5'd0;
        if (start) begin
            instruction = head_instr;
            operation   = head_op;
            rs1         = head_instr[19:15];
            rs2         = op_has_rs2(head_op) ? head_instr[24:20] : 5'd0;
            rd          = op_has_rd(head_op)  ? head_instr[11:7]  : 5'd0;
        end
    end

    assign count   = count_q;
    assign illegal = illegal_q;

endmodule
